sad_search_ctrl: RTL
====================

Name: sad_search_ctrl

Overview:
- Motion-search initiator for the pipelined 16x16 SAD engine.
- On `start`, walks every integer candidate displacement in a ±RANGE window in raster order and pulses `cal_en` once per candidate. The external reference fetcher aligns `refi` to `cand_mvx`/`cand_mvy`.
- Consumes the engine's in-order `sad`/`sad_vld` results, tracks the minimum SAD and its displacement, and reports the winner with a `done` pulse.
- Sits between the ME top-level sequencer and the SAD engine.

Parameters:
- RANGE, 8, search half-range; candidates per search = (2*RANGE+1)^2 (289 at default).
- SAD_W, 16, width of SAD results.
- MV_W, 5, signed two's-complement width of displacement outputs; must hold ±RANGE.
- CNT_W, 10, width of the issue, result and outstanding counters; must hold (2*RANGE+1)^2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a search; honoured only in IDLE.
- abort  in  1  cancel the current search; honoured in ISSUE and DRAIN.
- ref_rdy  in  1  the fetcher can present `refi` for the current candidate this cycle.
- cal_en  out  1  issue strobe to the SAD engine.
- cand_mvx  out  MV_W  signed x displacement, valid with `cal_en`.
- cand_mvy  out  MV_W  signed y displacement, valid with `cal_en`.
- sad  in  SAD_W  SAD result from the engine.
- sad_vld  in  1  `sad` valid this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a search completes normally.
- best_sad  out  SAD_W  minimum SAD of the last completed search.
- best_mvx  out  MV_W  x displacement of `best_sad`.
- best_mvy  out  MV_W  y displacement of `best_sad`.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, on `rst` sampled at the rising edge of `clk`.
- Reset values: all outputs 0; state = IDLE; all counters 0; running minimum = all-ones.
- States: IDLE, ISSUE, DRAIN, FLUSH, DONE.
- IDLE:
  - On `start`: load issue position (x,y) = (-RANGE,-RANGE) and result position = (-RANGE,-RANGE).
  - Set running min to {SAD_W{1}} and running mv to (0,0); go to ISSUE.
- ISSUE:
  - `cal_en` = `ref_rdy`, combinational from the state and the input.
  - `cand_mvx`/`cand_mvy` always drive the current issue position.
  - Each cycle with `cal_en`=1: advance issue position in raster order (x increments; at x=+RANGE, x wraps to -RANGE and y increments).
  - After issuing (+RANGE,+RANGE), go to DRAIN. No `cal_en` outside ISSUE.
- Outstanding counter:
  - +1 on `cal_en`, -1 on `sad_vld`; both in the same cycle leaves it unchanged.
  - Never decrements below 0; `sad_vld` with outstanding=0 is ignored in every state.
- Result handling (ISSUE and DRAIN, while outstanding>0 or `cal_en` is high in the same cycle):
  - On `sad_vld`: if `sad` < running min (strict), load running min = `sad` and running mv = result position.
  - Advance result position in the same raster order. Ties keep the earlier candidate.
- DRAIN: when the final result is accepted (result count reaches (2*RANGE+1)^2), go to DONE.
  - That final result takes part in the comparison.
- DONE (one cycle):
  - `done`=1; `best_sad`/`best_mvx`/`best_mvy` load the running values on entry; go to IDLE.
  - `best_*` hold until the next completed search.
- abort in ISSUE or DRAIN:
  - Go to FLUSH; stop issuing that cycle (`cal_en`=0 regardless of `ref_rdy`).
  - FLUSH absorbs `sad_vld` without comparison until outstanding=0, then goes to IDLE.
  - No `done`; `best_*` unchanged.
- Simultaneous `start` and `abort` in IDLE: `start` wins. `start` outside IDLE is ignored.
- `rst` mid-search: immediate return to reset values; in-flight engine results later arrive with outstanding=0 and are ignored.
- Latency:
  - Independent of engine depth; results are matched purely by order.
  - With `ref_rdy` held high and a 9-cycle engine, `done` asserts (2*RANGE+1)^2 + 9 + 1 cycles after the `start` cycle (299 at default).

Test Plan:
- Reset with all inputs at 0 -> all outputs 0, `busy`=0, no `cal_en` for 20 cycles.
- RANGE=2, `ref_rdy`=1, engine model returns SAD = |mvx-1|*10 + |mvy+2|*10 -> 25 `cal_en` pulses in raster order from (-2,-2); `done` after last result; `best_sad`=0, `best_mvx`=1, `best_mvy`=-2.
- All candidates return `sad`=100 -> `best_sad`=100, `best_mv`=(-RANGE,-RANGE) (tie keeps first).
- `ref_rdy` toggled 1-0-1-0 -> `cal_en` only on high cycles; still exactly (2R+1)^2 issues; result matches the ungated run.
- `abort` after 10 issues with 9 outstanding -> `cal_en` stops; `busy` stays high until 9 `sad_vld` absorbed; no `done`; `best_*` keep previous search values.
- `start` pulsed while busy, and spurious `sad_vld` in IDLE -> no effect on counters, state or outputs.

Source files
------------

// File: rtl/sad_search_ctrl.sv
// Motion-search initiator: issues every candidate of a +/-RANGE window in raster
// order to the SAD engine and keeps the minimum of the in-order results.
module sad_search_ctrl #(
  parameter int RANGE = 8,
  parameter int SAD_W = 16,
  parameter int MV_W  = 5,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             ref_rdy,
  output logic             cal_en,
  output logic [MV_W-1:0]  cand_mvx,
  output logic [MV_W-1:0]  cand_mvy,
  input  logic [SAD_W-1:0] sad,
  input  logic             sad_vld,
  output logic             busy,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [MV_W-1:0]  best_mvx,
  output logic [MV_W-1:0]  best_mvy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int              NCAND    = (2 * RANGE + 1) * (2 * RANGE + 1);
  localparam logic [MV_W-1:0] MV_MAX   = MV_W'(RANGE);
  localparam logic [MV_W-1:0] MV_MIN   = MV_W'(-RANGE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCAND - 1);

  logic [2:0]       state_reg, state_next;
  logic [MV_W-1:0]  ix_reg, ix_next, iy_reg, iy_next;
  logic [MV_W-1:0]  rx_reg, rx_next, ry_reg, ry_next;
  logic [CNT_W-1:0] res_cnt_reg, res_cnt_next;
  logic [CNT_W-1:0] out_cnt_reg, out_cnt_next;
  logic [SAD_W-1:0] min_sad_reg, min_sad_next;
  logic [MV_W-1:0]  min_mvx_reg, min_mvx_next, min_mvy_reg, min_mvy_next;
  logic [SAD_W-1:0] best_sad_reg;
  logic [MV_W-1:0]  best_mvx_reg, best_mvy_reg;

  logic active, accept, cmp_en, last_issue, last_result;

  assign active = (state_reg == S_ISSUE) || (state_reg == S_DRAIN);
  // abort suppresses the strobe in the very cycle it is seen
  assign cal_en = (state_reg == S_ISSUE) && ref_rdy && !abort;
  // results are only meaningful while something is (or is just being) in flight
  assign accept      = sad_vld && ((out_cnt_reg != '0) || cal_en);
  assign cmp_en      = accept && active;
  assign last_issue  = cal_en && (ix_reg == MV_MAX) && (iy_reg == MV_MAX);
  assign last_result = cmp_en && (res_cnt_reg == LAST_CNT);

  always_comb begin
    state_next   = state_reg;
    ix_next      = ix_reg;
    iy_next      = iy_reg;
    rx_next      = rx_reg;
    ry_next      = ry_reg;
    res_cnt_next = res_cnt_reg;
    out_cnt_next = out_cnt_reg;
    min_sad_next = min_sad_reg;
    min_mvx_next = min_mvx_reg;
    min_mvy_next = min_mvy_reg;

    case ({cal_en, accept})
      2'b10:   out_cnt_next = out_cnt_reg + 1'b1;
      2'b01:   out_cnt_next = out_cnt_reg - 1'b1;
      default: out_cnt_next = out_cnt_reg;
    endcase

    if (cal_en) begin
      ix_next = (ix_reg == MV_MAX) ? MV_MIN : ix_reg + 1'b1;
      iy_next = (ix_reg == MV_MAX) ? iy_reg + 1'b1 : iy_reg;
    end

    if (cmp_en) begin
      rx_next      = (rx_reg == MV_MAX) ? MV_MIN : rx_reg + 1'b1;
      ry_next      = (rx_reg == MV_MAX) ? ry_reg + 1'b1 : ry_reg;
      res_cnt_next = res_cnt_reg + 1'b1;
      if (sad < min_sad_reg) begin
        min_sad_next = sad;
        min_mvx_next = rx_reg;
        min_mvy_next = ry_reg;
      end
    end

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next   = S_ISSUE;
          ix_next      = MV_MIN;
          iy_next      = MV_MIN;
          rx_next      = MV_MIN;
          ry_next      = MV_MIN;
          res_cnt_next = '0;
          min_sad_next = '1;
          min_mvx_next = '0;
          min_mvy_next = '0;
        end
      end
      S_ISSUE: begin
        if (abort)            state_next = S_FLUSH;
        else if (last_result) state_next = S_DONE;
        else if (last_issue)  state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)            state_next = S_FLUSH;
        else if (last_result) state_next = S_DONE;
      end
      S_FLUSH: begin
        if (out_cnt_next == '0) state_next = S_IDLE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      ix_reg       <= '0;
      iy_reg       <= '0;
      rx_reg       <= '0;
      ry_reg       <= '0;
      res_cnt_reg  <= '0;
      out_cnt_reg  <= '0;
      min_sad_reg  <= '1;
      min_mvx_reg  <= '0;
      min_mvy_reg  <= '0;
      best_sad_reg <= '0;
      best_mvx_reg <= '0;
      best_mvy_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ix_reg      <= ix_next;
      iy_reg      <= iy_next;
      rx_reg      <= rx_next;
      ry_reg      <= ry_next;
      res_cnt_reg <= res_cnt_next;
      out_cnt_reg <= out_cnt_next;
      min_sad_reg <= min_sad_next;
      min_mvx_reg <= min_mvx_next;
      min_mvy_reg <= min_mvy_next;
      // winner includes the final result accepted on the way into DONE
      if (state_next == S_DONE) begin
        best_sad_reg <= min_sad_next;
        best_mvx_reg <= min_mvx_next;
        best_mvy_reg <= min_mvy_next;
      end
    end
  end

  assign cand_mvx = ix_reg;
  assign cand_mvy = iy_reg;
  assign busy     = (state_reg != S_IDLE);
  assign done     = (state_reg == S_DONE);
  assign best_sad = best_sad_reg;
  assign best_mvx = best_mvx_reg;
  assign best_mvy = best_mvy_reg;

endmodule
